// File: rtl/bf2ii_sdf.sv
// Radix-2^2 BF2II single-path delay-feedback stage with its own delay line,
// trivial +/-j twiddle, selectable scaling/saturation and an explicit drain.
module bf2ii_sdf #(
  parameter int unsigned HWIDTH    = 16,
  parameter int unsigned DEPTH_LOG = 3,
  parameter int unsigned SCALE     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic [2*HWIDTH-1:0]   i_data,
  input  logic                  i_inverse,
  input  logic                  i_flush,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [2*HWIDTH-1:0]   o_data,
  output logic                  o_ovf
);

  localparam int N  = 1 << DEPTH_LOG;
  localparam int CW = DEPTH_LOG + 2;
  localparam int DW = DEPTH_LOG + 1;

  // Two's complement negate that maps the most negative value to the most positive.
  function automatic logic [HWIDTH-1:0] neg_sat(input logic [HWIDTH-1:0] a);
    if (a == {1'b1, {(HWIDTH-1){1'b0}}}) return {1'b0, {(HWIDTH-1){1'b1}}};
    return -a;
  endfunction

  function automatic logic [HWIDTH:0] ext(input logic [HWIDTH-1:0] a);
    return {a[HWIDTH-1], a};
  endfunction

  // Returns {clip, value}. Round-half-up halving is v[H:1] + v[0].
  function automatic logic [HWIDTH:0] f_scale(input logic [HWIDTH:0] v);
    if (SCALE != 0) return {1'b0, v[HWIDTH:1] + HWIDTH'(v[0])};
    if (v[HWIDTH] != v[HWIDTH-1]) return {1'b1, v[HWIDTH], {(HWIDTH-1){~v[HWIDTH]}}};
    return {1'b0, v[HWIDTH-1:0]};
  endfunction

  logic [CW-1:0]         r_cnt;
  logic                  r_primed;
  logic [DW-1:0]         r_drain;
  logic [2*HWIDTH-1:0]   r_dly [N];
  logic                  r_valid;
  logic [2*HWIDTH-1:0]   r_data;
  logic                  r_ovf;

  logic                  w_ready;
  logic                  w_draining;
  logic                  w_adv;
  logic                  w_honour;
  logic                  w_s;
  logic [1:0]            w_q;
  logic [HWIDTH-1:0]     w_in_re;
  logic [HWIDTH-1:0]     w_in_im;
  logic [HWIDTH-1:0]     w_x_re;
  logic [HWIDTH-1:0]     w_x_im;
  logic [HWIDTH-1:0]     w_d_re;
  logic [HWIDTH-1:0]     w_d_im;
  logic [HWIDTH:0]       w_sum_re;
  logic [HWIDTH:0]       w_sum_im;
  logic [HWIDTH:0]       w_dif_re;
  logic [HWIDTH:0]       w_dif_im;
  logic [2*HWIDTH-1:0]   w_out;
  logic [2*HWIDTH-1:0]   w_push;
  logic                  w_clip;

  assign w_ready    = (r_drain == '0);
  assign w_draining = ~w_ready;
  assign w_adv      = (i_valid & w_ready) | w_draining;
  assign w_honour   = i_flush & w_ready & (r_cnt[DEPTH_LOG:0] == '0);
  assign w_s        = r_cnt[DEPTH_LOG];
  assign w_q        = r_cnt[CW-1:DEPTH_LOG];

  assign w_in_re = i_data[2*HWIDTH-1:HWIDTH];
  assign w_in_im = i_data[HWIDTH-1:0];
  assign w_d_re  = r_dly[0][2*HWIDTH-1:HWIDTH];
  assign w_d_im  = r_dly[0][HWIDTH-1:0];

  always_comb begin
    w_x_re = w_in_re;
    w_x_im = w_in_im;
    if (w_draining) begin
      w_x_re = '0;
      w_x_im = '0;
    end else if (w_q == 2'b11) begin
      if (i_inverse) begin
        w_x_re = neg_sat(w_in_im);
        w_x_im = w_in_re;
      end else begin
        w_x_re = w_in_im;
        w_x_im = neg_sat(w_in_re);
      end
    end
  end

  assign w_sum_re = f_scale(ext(w_d_re) + ext(w_x_re));
  assign w_sum_im = f_scale(ext(w_d_im) + ext(w_x_im));
  assign w_dif_re = f_scale(ext(w_d_re) - ext(w_x_re));
  assign w_dif_im = f_scale(ext(w_d_im) - ext(w_x_im));

  always_comb begin
    w_out  = r_dly[0];
    w_push = {w_x_re, w_x_im};
    w_clip = 1'b0;
    if (w_s) begin
      w_out  = {w_sum_re[HWIDTH-1:0], w_sum_im[HWIDTH-1:0]};
      w_push = {w_dif_re[HWIDTH-1:0], w_dif_im[HWIDTH-1:0]};
      w_clip = w_sum_re[HWIDTH] | w_sum_im[HWIDTH] | w_dif_re[HWIDTH] | w_dif_im[HWIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_primed <= 1'b0;
      r_drain  <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_ovf    <= 1'b0;
      for (int i = 0; i < N; i++) r_dly[i] <= '0;
    end else begin
      r_valid <= w_adv & r_primed;
      if (w_adv) begin
        if (r_primed) r_data <= w_out;
        if (w_clip) r_ovf <= 1'b1;
        for (int i = 0; i < N - 1; i++) r_dly[i] <= r_dly[i+1];
        r_dly[N-1] <= w_push;
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == CW'(N - 1)) r_primed <= 1'b1;
      end
      // The last drain cycle rewinds the stage to its post-reset control state.
      if (w_honour) begin
        r_drain <= DW'(N);
      end else if (w_draining) begin
        r_drain <= r_drain - DW'(1);
        if (r_drain == DW'(1)) begin
          r_cnt    <= '0;
          r_primed <= 1'b0;
        end
      end
    end
  end

  assign o_ready = w_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ovf   = r_ovf;

endmodule
